// File: rtl/sram_btn_seq.sv
// Button-driven SRAM access sequencer: turns debounced command pulses into
// single req/ack transactions with a timeout and holds the last read word.
module sram_btn_seq #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_btn,
  input  logic          rd_btn,
  input  logic          inc_btn,
  input  logic          clr_btn,
  input  logic [DW-1:0] sw_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] disp_data,
  output logic          busy,
  output logic          err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Strict priority clr > wr > rd > inc, reduced to one-hot
  logic do_clr, do_wr, do_rd, do_inc;
  assign do_clr = clr_btn;
  assign do_wr  = wr_btn & ~clr_btn;
  assign do_rd  = rd_btn & ~wr_btn & ~clr_btn;
  assign do_inc = inc_btn & ~rd_btn & ~wr_btn & ~clr_btn;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    disp_d  = disp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          do_clr: begin
            addr_d = '0;
            err_d  = 1'b0;
          end
          do_wr: begin
            we_d    = 1'b1;
            wdata_d = sw_data;
            cnt_d   = '0;
            state_d = S_REQ;
          end
          do_rd: begin
            we_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_REQ;
          end
          do_inc: addr_d = addr_q + AW'(1);
          default: ;
        endcase
      end
      S_REQ: begin
        if (mem_ack) begin
          if (we_q) addr_d = addr_q + AW'(1);
          else      disp_d = mem_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign busy      = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign disp_data = disp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sram_btn_seq.sv
// Directed bench for sram_btn_seq: vector table plus hand-written
// sequences for wrap, timeout and mid-transaction reset.
module tb_sram_btn_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_btn, rd_btn, inc_btn, clr_btn, mem_ack;
  logic [15:0] sw_data, mem_rdata;

  logic        mem_req, mem_we, busy, err;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata, disp_data;

  logic        req_s, we_s, busy_s, err_s;
  logic [2:0]  addr_s;
  logic [15:0] wdata_s, disp_s;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  sram_btn_seq #(.AW(18), .DW(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_btn(wr_btn), .rd_btn(rd_btn),
    .inc_btn(inc_btn), .clr_btn(clr_btn),
    .sw_data(sw_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .disp_data(disp_data), .busy(busy), .err(err)
  );

  // Narrow-address copy so the all-ones wrap is reachable quickly
  sram_btn_seq #(.AW(3), .DW(16), .TIMEOUT(16)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .wr_btn(wr_btn), .rd_btn(rd_btn),
    .inc_btn(inc_btn), .clr_btn(clr_btn),
    .sw_data(sw_data),
    .mem_req(req_s), .mem_we(we_s),
    .mem_addr(addr_s), .mem_wdata(wdata_s),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .disp_data(disp_s), .busy(busy_s), .err(err_s)
  );

  typedef struct {
    logic        wr, rd, inc, clr, ack;
    logic [15:0] sw, rdat;
    logic        req, we;
    logic [17:0] addr;
    logic [15:0] wd, disp;
    logic        err;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic wr, rd, inc, clr, ack,
    input logic [15:0] sw, rdat,
    input logic req, we, input logic [17:0] addr,
    input logic [15:0] wd, disp, input logic e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.inc = inc; v.clr = clr; v.ack = ack;
    v.sw = sw; v.rdat = rdat; v.req = req; v.we = we;
    v.addr = addr; v.wd = wd; v.disp = disp; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, rd, inc, clr, ack,
                      input logic [15:0] sw, rdat);
    @(negedge clk);
    wr_btn = wr; rd_btn = rd; inc_btn = inc; clr_btn = clr;
    mem_ack = ack; sw_data = sw; mem_rdata = rdat;
    @(posedge clk);
    #1;
    wr_btn = 0; rd_btn = 0; inc_btn = 0; clr_btn = 0; mem_ack = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    wr_btn = 0; rd_btn = 0; inc_btn = 0; clr_btn = 0; mem_ack = 0;
    sw_data = 0; mem_rdata = 0;

    //            wr rd in cl ak sw        rdat      req we addr wd  disp  err
    tbl[0]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 16'h1234, 16'h0000, 1, 1, 0, 16'h1234, 16'h0000, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h1234, 16'h0000, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h1234, 16'h0000, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 16'h1234, 16'h0000, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1234, 16'h0000, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 16'h9999, 16'h0000, 1, 0, 0, 16'h1234, 16'h0000, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, 0, 0, 0, 16'h1234, 16'hBEEF, 0);
    tbl[8]  = mk(1, 1, 0, 0, 0, 16'h5555, 16'h0000, 1, 1, 0, 16'h5555, 16'hBEEF, 0);
    tbl[9]  = mk(0, 1, 1, 1, 0, 16'h6666, 16'h0000, 1, 1, 0, 16'h5555, 16'hBEEF, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 16'h5555, 16'hBEEF, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h1111, 0, 1, 1, 16'h5555, 16'hBEEF, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 2, 16'h5555, 16'hBEEF, 0);
    tbl[13] = mk(1, 0, 1, 1, 0, 16'h7777, 16'h0000, 0, 1, 0, 16'h5555, 16'hBEEF, 0);
    tbl[14] = mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h5555, 16'hBEEF, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 16'h0000, 16'hCAFE, 0, 0, 0, 16'h5555, 16'hCAFE, 0);

    #25;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_disp", disp_data, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].inc, tbl[i].clr,
           tbl[i].ack, tbl[i].sw, tbl[i].rdat);
      chk($sformatf("v%0d_req", i), mem_req, tbl[i].req);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].req);
      chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d_disp", i), disp_data, tbl[i].disp);
      chk($sformatf("v%0d_err", i), err, tbl[i].err);
    end

    // Address wrap via inc and via write completion
    step(0, 0, 0, 1, 0, 16'h0, 16'h0);
    repeat (7) step(0, 0, 1, 0, 0, 16'h0, 16'h0);
    chk("wrap_pre_s", addr_s, 7);
    chk("wrap_pre", mem_addr, 7);
    step(0, 0, 1, 0, 0, 16'h0, 16'h0);
    chk("wrap_inc_s", addr_s, 0);
    chk("wrap_inc", mem_addr, 8);
    step(0, 0, 0, 1, 0, 16'h0, 16'h0);
    repeat (7) step(0, 0, 1, 0, 0, 16'h0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0F0F, 16'h0);
    chk("wrap_wr_req", req_s, 1);
    chk("wrap_wr_addr", addr_s, 7);
    step(0, 0, 0, 0, 1, 16'h0, 16'h0);
    chk("wrap_wr_s", addr_s, 0);
    chk("wrap_wr", mem_addr, 8);

    // Timeout with no ack
    step(0, 0, 0, 1, 0, 16'h0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0, 16'h0);
    step(1, 0, 0, 0, 0, 16'hDEAD, 16'h0);
    n = mem_req ? 1 : 0;
    while (mem_req && n <= 40) begin
      idle();
      if (mem_req) n++;
    end
    chk("to_cycles", n, 16);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_addr", mem_addr, 1);
    chk("to_disp", disp_data, 16'hCAFE);
    step(0, 0, 0, 1, 0, 16'h0, 16'h0);
    chk("to_clr_err", err, 0);
    chk("to_clr_addr", mem_addr, 0);

    // Ack on the final allowed cycle beats the timeout
    step(1, 0, 0, 0, 0, 16'hABCD, 16'h0);
    repeat (15) idle();
    chk("to_last_req", mem_req, 1);
    step(0, 0, 0, 0, 1, 16'h0, 16'h0);
    chk("to_ack_req", mem_req, 0);
    chk("to_ack_err", err, 0);
    chk("to_ack_addr", mem_addr, 1);

    // Reset in the middle of a transaction
    step(1, 0, 0, 0, 0, 16'hA5A5, 16'h0);
    chk("mr_req_pre", mem_req, 1);
    #10;
    rst_n = 0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_wdata", mem_wdata, 0);
    chk("mr_disp", disp_data, 0);
    chk("mr_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0, 1, 16'h0, 16'h7777);
    chk("mr_ack_req", mem_req, 0);
    chk("mr_ack_addr", mem_addr, 0);
    chk("mr_ack_disp", disp_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_btn_seq.md
# sram_btn_seq

Button-driven SRAM access sequencer, directly downstream of the per-button debounce stages. It takes single-cycle debounced pulses for write, read, address-increment and address-clear. It turns each accepted write or read into one req/ack transaction toward the SRAM controller, and holds the last read word for the display.

## Interface
- AW, 18, SRAM word-address width
- DW, 16, SRAM data width
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack (≥2)

- clk  in  1  system clock, 10 MHz
- rst_n  in  1  asynchronous, active-low reset
- wr_btn  in  1  debounced single-cycle write pulse
- rd_btn  in  1  debounced single-cycle read pulse
- inc_btn  in  1  debounced single-cycle address +1 pulse
- clr_btn  in  1  debounced single-cycle address clear / error clear pulse
- sw_data  in  DW  write data from switches
- mem_req  out  1  transaction request to SRAM controller
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  AW  current word address (also drives address display)
- mem_wdata  out  DW  write data; valid while mem_req
- mem_ack  in  1  single-cycle completion from controller
- mem_rdata  in  DW  read data, valid in the mem_ack cycle
- disp_data  out  DW  last successfully read word
- busy  out  1  high while a transaction is outstanding
- err  out  1  sticky timeout flag

## Operation
- Two states:
  - IDLE: mem_req=0, busy=0.
  - REQ: mem_req=1, busy=1.
- Input priority in IDLE on the same edge: clr_btn > wr_btn > rd_btn > inc_btn. Only the highest-priority pulse acts; the others are discarded.
- clr_btn (IDLE): mem_addr←0, err←0, stay IDLE.
- wr_btn (IDLE): mem_we←1, mem_wdata←sw_data, timeout counter←0, go to REQ.
- rd_btn (IDLE): mem_we←0, timeout counter←0, go to REQ. mem_wdata is unchanged.
- inc_btn (IDLE): mem_addr←mem_addr+1 modulo 2^AW, so all-ones wraps to 0. Stay IDLE.
- REQ exit on mem_ack=1:
  - write: mem_addr←mem_addr+1 (same wrap rule).
  - read: disp_data←mem_rdata, mem_addr unchanged.
  - both: go to IDLE.
- REQ exit on timeout: if the counter reaches TIMEOUT-1 with mem_ack=0, set err←1, leave mem_addr and disp_data unchanged, go to IDLE.
- mem_ack on the same edge as timeout expiry: the ack wins and err is not set.
- mem_ack while in IDLE is ignored.
- All button pulses (including clr_btn) arriving in REQ are dropped, not queued.
- mem_we, mem_addr and mem_wdata are stable for the whole time mem_req is high.
- Timeout counter width is $clog2(TIMEOUT). It counts only in REQ.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately):
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_data=0, busy=0, err=0, state=IDLE, counter=0.
  - Reset in the middle of REQ abandons the transaction with no ack required. mem_req falls without waiting for a clock.
- Command pulse sampled at edge N: mem_req and busy are high after edge N.
- mem_ack sampled at edge M: mem_req and busy are low after edge M; mem_addr / disp_data are updated after edge M.
- A new command is accepted no earlier than edge M+1, which gives at least one idle cycle between requests.
- Zero-wait controller (ack at the first edge after req rises): the transaction takes 2 edges from the button pulse to IDLE.
- Timeout: mem_req stays high for exactly TIMEOUT cycles, then drops with err high on the same edge.
- inc_btn / clr_btn: mem_addr changes after the sampling edge (1-cycle latency).

## Test plan
- Reset, then wr_btn with sw_data=0x1234 and ack 3 cycles later → mem_req high 3 cycles, mem_we=1, mem_wdata=0x1234, mem_addr=0 during req; mem_addr=1 after ack.
- clr_btn, then rd_btn with ack carrying mem_rdata=0xBEEF → disp_data=0xBEEF, mem_addr stays 0, mem_we=0 during req.
- mem_addr=0x3FFFF, inc_btn → mem_addr=0; a write at 0x3FFFF with ack likewise → 0.
- TIMEOUT=16 with no ack → mem_req high exactly 16 cycles, err=1, addr unchanged. A following clr_btn → err=0, addr=0. Repeat with ack on the 16th cycle → err stays 0.
- wr_btn and rd_btn on the same edge → write only. Pulses of rd/inc/clr while busy → no effect on addr, disp_data or state.
- rst_n low mid-REQ → mem_req, busy and all outputs are 0 immediately. A later mem_ack is ignored.
